// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency synchronous memory between two
// requesters; one transaction in flight, read data returned to the owning port.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          err0,
    output logic          err1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state_o
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // Handshake: a port holds req/we/addr/wdata stable until its one-cycle gnt;
    // the grant cycle is the single mem_en cycle, and rvalid follows RD_LAT+1
    // cycles later for reads.
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state_q;
    logic            last_owner_q;
    logic            owner_q;
    logic            we_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      gnt_q;
    logic [1:0]      err_out_q;
    logic [1:0]      rvalid_q;
    logic [DW-1:0]   rdata0_q;
    logic [DW-1:0]   rdata1_q;
    logic            mem_en_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic            win_d;
    logic            owner_d;
    logic            we_d;
    logic            mis_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdata_d;

    // On a tie the port that did not own the last transaction wins.
    always_comb begin
        win_d   = req0 | req1;
        owner_d = (req0 && req1) ? ~last_owner_q : req1;
        we_d    = owner_d ? we1 : we0;
        addr_d  = owner_d ? addr1 : addr0;
        wdata_d = owner_d ? wdata1 : wdata0;
        mis_d   = (addr_d[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= 2'b00;
            err_out_q    <= 2'b00;
            rvalid_q     <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            gnt_q     <= 2'b00;
            err_out_q <= 2'b00;
            rvalid_q  <= 2'b00;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_d) begin
                        owner_q      <= owner_d;
                        last_owner_q <= owner_d;
                        we_q         <= we_d;
                        err_q        <= mis_d;
                        gnt_q        <= {owner_d, ~owner_d};
                        if (mis_d) begin
                            err_out_q <= {owner_d, ~owner_d};
                        end else begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= we_d;
                            mem_addr_q  <= {addr_d[AW-1:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (err_q || we_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= CW'(RD_LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt_q reaches zero in the cycle mem_rdata is valid.
                    if (cnt_q == '0) begin
                        if (owner_q) rdata1_q <= mem_rdata;
                        else         rdata0_q <= mem_rdata;
                        rvalid_q[owner_q] <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign err0        = err_out_q[0];
    assign err1        = err_out_q[1];
    assign rvalid0     = rvalid_q[0];
    assign rvalid1     = rvalid_q[1];
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RD_LAT=2 instance driven from a transaction
// table plus corner sequences, and a RD_LAT=1 instance for back-to-back reads.
module tb_mem_port_arbiter;

    localparam int RDL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(RDL)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    // RD_LAT=1 instance, only port 0 is exercised
    logic        r_req0 = 0, r_we0 = 0;
    logic [31:0] r_addr0 = 0;
    logic        r_req1 = 0, r_we1 = 0;
    logic [31:0] r_addr1 = 0, r_wdata0 = 0, r_wdata1 = 0;
    logic        r_gnt0, r_gnt1, r_err0, r_err1, r_rvalid0, r_rvalid1, r_mem_en, r_mem_we;
    logic [31:0] r_rdata0, r_rdata1, r_mem_addr, r_mem_wdata, r_mem_rdata;
    logic [1:0]  r_dbg_state;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .req0(r_req0), .req1(r_req1), .we0(r_we0), .we1(r_we1),
        .addr0(r_addr0), .addr1(r_addr1), .wdata0(r_wdata0), .wdata1(r_wdata1),
        .gnt0(r_gnt0), .gnt1(r_gnt1), .err0(r_err0), .err1(r_err1),
        .rvalid0(r_rvalid0), .rvalid1(r_rvalid1), .rdata0(r_rdata0), .rdata1(r_rdata1),
        .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_rdata(r_mem_rdata), .dbg_state_o(r_dbg_state)
    );

    // Memory models: read data is valid only in the RD_LAT-th cycle after mem_en
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic        p1_v = 0, p2_v = 0, q_v = 0;
    logic [31:0] p1_d = 0, p2_d = 0, q_d = 0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[4] = 32'hDEADBEEF;
        mem_b[0] = 32'h1111AAAA;
        mem_b[1] = 32'h2222BBBB;
    end

    always @(posedge clk) begin
        p1_v <= mem_en && !mem_we;
        p1_d <= mem_a[mem_addr[7:2]];
        p2_v <= p1_v;
        p2_d <= p1_d;
        if (mem_en && mem_we) mem_a[mem_addr[7:2]] <= mem_wdata;
        q_v <= r_mem_en && !r_mem_we;
        q_d <= mem_b[r_mem_addr[7:2]];
    end
    assign mem_rdata   = p2_v ? p2_d : 32'hBADC0DE0;
    assign r_mem_rdata = q_v ? q_d : 32'hBADC0DE1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected read data per port, popped on rvalid
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] last0 = 0, last1 = 0;
    logic        mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("one_gnt", {31'b0, gnt0 & gnt1}, 32'h0);
            if (exp_q0.size() == 0) check("rvalid0_spurious", {31'b0, rvalid0}, 32'h0);
            if (exp_q1.size() == 0) check("rvalid1_spurious", {31'b0, rvalid1}, 32'h0);
            if (rvalid0 && exp_q0.size() != 0) last0 = exp_q0.pop_front();
            if (rvalid1 && exp_q1.size() != 0) last1 = exp_q1.pop_front();
            check("rdata0", rdata0, last0);
            check("rdata1", rdata1, last1);
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic drive(input bit port, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt_err_rv"}, {26'b0, gnt0, gnt1, err0, err1, rvalid0, rvalid1}, 32'h0);
        check({tag, "_mem_en_we"}, {30'b0, mem_en, mem_we}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_rdata0"}, rdata0, 32'h0);
        check({tag, "_rdata1"}, rdata1, 32'h0);
        check({tag, "_state"}, {30'b0, dbg_state}, 32'h0);
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        logic [31:0] ea;
        logic g;
        ea = {v.addr[31:2], 2'b00};
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        n = 0;
        g = 1'b0;
        while (n < 20 && !g) begin
            @(posedge clk); #1;
            n++;
            g = v.port ? gnt1 : gnt0;
        end
        check("gnt_latency", n, 1);
        drive(v.port, 1'b0, 1'b0, v.addr, v.wdata);
        if (!g) return;
        check("err", {31'b0, v.port ? err1 : err0}, {31'b0, v.exp_err});
        check("other_gnt", {31'b0, v.port ? gnt0 : gnt1}, 32'h0);
        check("mem_en", {31'b0, mem_en}, {31'b0, !v.exp_err});
        check("mem_we", {31'b0, mem_we}, {31'b0, v.we && !v.exp_err});
        if (!v.exp_err) check("mem_addr", mem_addr, ea);
        if (!v.exp_err && v.we) check("mem_wdata", mem_wdata, v.wdata);
        if (v.exp_err || v.we) begin
            @(posedge clk); #1;
            check("mem_en_after", {30'b0, mem_en, mem_we}, 32'h0);
            if (!v.exp_err) check("mem_addr_hold", mem_addr, ea);
        end else begin
            if (v.port) exp_q1.push_back(v.exp_rdata);
            else        exp_q0.push_back(v.exp_rdata);
            n = 0;
            g = 1'b0;
            while (n < 12 && !g) begin
                @(posedge clk); #1;
                n++;
                g = v.port ? rvalid1 : rvalid0;
            end
            check("rvalid_latency", n, RDL + 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q0.delete();
        exp_q1.delete();
        last0 = 0;
        last1 = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int order[6];
        int k, n;
        logic [31:0] a, d;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h31, 32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h08, 32'hA5A55A5A, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h08, 32'h0,        1'b0, 32'hA5A55A5A};
        vecs[8] = '{1'b0, 1'b0, 32'h22, 32'h0,        1'b1, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Fairness: both ports requesting continuously from reset
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h0000AAAA);
        drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h0000BBBB);
        k = 0;
        n = 0;
        while (k < 6 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (gnt0) begin order[k] = 0; k++; end
            else if (gnt1) begin order[k] = 1; k++; end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("fair_count", k, 6);
        for (int i = 0; i < k; i++) check("fair_order", order[i], i % 2);
        @(posedge clk); #1;

        // Transaction table
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Random write/read-back pairs
        for (int i = 0; i < 6; i++) begin
            a = {24'h0, 6'($urandom_range(12, 63)), 2'b00};
            d = $urandom;
            v = '{1'($urandom_range(0, 1)), 1'b1, a, d, 1'b0, 32'h0};
            do_txn(v);
            v = '{1'($urandom_range(0, 1)), 1'b0, a, 32'h0, 1'b0, d};
            do_txn(v);
        end

        // Reset during WAIT of a port-1 read, with requests pending
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        n = 0;
        while (n < 20 && !gnt1) begin @(posedge clk); #1; n++; end
        check("rst_wait_gnt1", {31'b0, gnt1}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h48, 32'h00001111);
        drive(1'b1, 1'b1, 1'b1, 32'h4C, 32'h00002222);
        @(posedge clk); #1;
        exp_q0.delete();
        exp_q1.delete();
        last0 = 0;
        last1 = 0;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 20 && !(gnt0 || gnt1)) begin @(posedge clk); #1; n++; end
        check("rst_tie_gnt0", {31'b0, gnt0}, 32'h1);
        check("rst_tie_gnt1", {31'b0, gnt1}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (n < 20 && !gnt1) begin @(posedge clk); #1; n++; end
        check("rst_second_gnt1", {31'b0, gnt1}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // RD_LAT=1 instance: back-to-back port-0 reads of 0x0 and 0x4
        @(negedge clk);
        r_req0 = 1'b1;
        r_we0 = 1'b0;
        r_addr0 = 32'h0;
        n = 0;
        while (n < 20 && !r_gnt0) begin @(posedge clk); #1; n++; end
        check("l1_gnt_a", n, 1);
        check("l1_mem_addr_a", r_mem_addr, 32'h0);
        r_addr0 = 32'h4;
        n = 0;
        while (n < 12 && !r_rvalid0) begin @(posedge clk); #1; n++; end
        check("l1_rvalid_lat_a", n, 2);
        check("l1_rdata_a", r_rdata0, 32'h1111AAAA);
        n = 0;
        while (n < 20 && !r_gnt0) begin
            @(posedge clk); #1; n++;
            check("l1_rdata_hold", r_rdata0, 32'h1111AAAA);
        end
        check("l1_gnt_b", {31'b0, r_gnt0}, 32'h1);
        check("l1_mem_addr_b", r_mem_addr, 32'h4);
        r_req0 = 1'b0;
        n = 0;
        while (n < 12 && !r_rvalid0) begin
            @(posedge clk); #1; n++;
            if (!r_rvalid0) check("l1_rdata_hold2", r_rdata0, 32'h1111AAAA);
        end
        check("l1_rvalid_lat_b", n, 2);
        check("l1_rdata_b", r_rdata0, 32'h2222BBBB);
        repeat (3) @(posedge clk);
        #1;

        mon_en = 1'b0;
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
